// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the matmul operand feeder.
//   state_t       - feeder FSM state encoding (IDLE, FETCH, DRAIN, DONE)
//   drain_cycles  - cycles spent in DRAIN for a given grid dimension
//   lanes         - number of operand lanes held by one memory word
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Covers the skew of the last lane plus the trip across the grid to the
  // far-corner PE and its final accumulate.
  function automatic int drain_cycles(input int dimension);
    return 2 * dimension + 2;
  endfunction

  function automatic int lanes(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

endpackage

// File: rtl/matmul_operand_feeder_skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift register with synchronous reset.
// DEPTH = 0 is a plain wire.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_data         : data in
//   o_data         : data delayed by DEPTH cycles
module skew_delay_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused_ctl;
    assign w_unused_ctl = i_clk ^ i_reset;
    assign o_data = i_data;
  end else begin : g_shift
    logic [DATA_WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        for (int d = 0; d < DEPTH; d++) r_sr[d] <= '0;
      end else begin
        r_sr[0] <= i_data;
        for (int d = 1; d < DEPTH; d++) r_sr[d] <= r_sr[d-1];
      end
    end

    assign o_data = r_sr[DEPTH-1];
  end

endmodule

// File: rtl/matmul_operand_feeder.sv
// matmul_operand_feeder: fetches operand columns of A / rows of B, one k per
// cycle, and drives them diagonally skewed into row 0 / column 0 of the PE
// grid. Pulses o_calc_done once the far-corner PE holds its final result.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_start                 : begin a multiply (only seen in IDLE)
//   i_n_dim, i_k_dim        : active matrix size, inner dimension (0 legal)
//   o_mem_rd_en, o_mem_addr : operand memory read, 1-cycle latency
//   i_a_mem_rdata           : column k of A (lane i = A[i][k])
//   i_b_mem_rdata           : row k of B (lane j = B[k][j])
//   o_a_out, o_b_out        : skewed operand lanes into the grid
//   o_busy                  : high in FETCH and DRAIN
//   o_calc_done             : one-cycle completion pulse
//   o_dbg_state             : current FSM state
//
// Handshake: there is no backpressure. A read issued with o_mem_rd_en in
// cycle t returns data in cycle t+1; lane i of that data reaches o_a_out /
// o_b_out in cycle t+2+i, and every slot without fetched data carries 0.
module matmul_operand_feeder
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 64,
  parameter int DIMENSION  = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic [$clog2(DIMENSION):0]      i_n_dim,
  input  logic [ADDR_WIDTH-1:0]           i_k_dim,
  output logic                            o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]           o_mem_addr,
  input  logic [BUS_WIDTH-1:0]            i_a_mem_rdata,
  input  logic [BUS_WIDTH-1:0]            i_b_mem_rdata,
  output logic [DIMENSION*DATA_WIDTH-1:0] o_a_out,
  output logic [DIMENSION*DATA_WIDTH-1:0] o_b_out,
  output logic                            o_busy,
  output logic                            o_calc_done,
  output state_t                          o_dbg_state
);

  localparam int NW           = $clog2(DIMENSION) + 1;
  localparam int DRAIN_CYCLES = drain_cycles(DIMENSION);
  localparam int CW           = $clog2(DRAIN_CYCLES);
  localparam int LANES        = lanes(BUS_WIDTH, DATA_WIDTH);

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_k;
  logic [ADDR_WIDTH-1:0] r_kdim;
  logic [NW-1:0]         r_n_dim;
  logic [CW-1:0]         r_cnt;
  logic                  r_rd_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_kdim     <= '0;
      r_n_dim    <= '0;
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_valid <= o_mem_rd_en;
      case (r_state)
        ST_IDLE: begin
          r_k   <= '0;
          r_cnt <= '0;
          if (i_start) begin
            r_n_dim <= i_n_dim;
            r_kdim  <= i_k_dim;
          end
        end
        ST_FETCH: r_k   <= r_k + ADDR_WIDTH'(1);
        ST_DRAIN: r_cnt <= r_cnt + CW'(1);
        default:  ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    o_mem_rd_en = 1'b0;
    o_mem_addr  = '0;
    o_busy      = 1'b0;
    o_calc_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = (i_k_dim != '0) ? ST_FETCH : ST_DONE;
      end
      ST_FETCH: begin
        o_mem_rd_en = 1'b1;
        o_mem_addr  = r_k;
        o_busy      = 1'b1;
        if (r_k == r_kdim - ADDR_WIDTH'(1)) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        if (r_cnt == CW'(DRAIN_CYCLES - 1)) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_calc_done = 1'b1;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign o_dbg_state = r_state;

  // Memory lanes beyond the grid size carry nothing for this feeder.
  if (DIMENSION < LANES) begin : g_unused_lanes
    logic w_unused_lanes;
    assign w_unused_lanes = ^{i_a_mem_rdata[BUS_WIDTH-1:DIMENSION*DATA_WIDTH],
                              i_b_mem_rdata[BUS_WIDTH-1:DIMENSION*DATA_WIDTH]};
  end

  for (genvar i = 0; i < DIMENSION; i++) begin : g_lane
    localparam logic [NW-1:0] LANE_IDX = NW'(i);

    logic                  w_lane_en;
    logic [DATA_WIDTH-1:0] w_a_in, w_b_in, w_a_skew, w_b_skew;
    logic [DATA_WIDTH-1:0] r_a_out, r_b_out;

    assign w_lane_en = (LANE_IDX < r_n_dim);

    // Zero-fill: anything but freshly returned read data enters as 0, so
    // the PEs may keep accumulating outside the valid window harmlessly.
    assign w_a_in = (r_rd_valid && w_lane_en) ?
                    i_a_mem_rdata[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign w_b_in = (r_rd_valid && w_lane_en) ?
                    i_b_mem_rdata[i*DATA_WIDTH +: DATA_WIDTH] : '0;

    skew_delay_line #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_a_skew (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_data  (w_a_in),
      .o_data  (w_a_skew)
    );

    skew_delay_line #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_b_skew (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_data  (w_b_in),
      .o_data  (w_b_skew)
    );

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_a_out <= '0;
        r_b_out <= '0;
      end else begin
        r_a_out <= w_a_skew;
        r_b_out <= w_b_skew;
      end
    end

    // Output mask also hides values still in flight when a new, smaller
    // n_dim is latched.
    assign o_a_out[i*DATA_WIDTH +: DATA_WIDTH] = w_lane_en ? r_a_out : '0;
    assign o_b_out[i*DATA_WIDTH +: DATA_WIDTH] = w_lane_en ? r_b_out : '0;
  end

endmodule
